nasti_slice: RTL and testbench
==============================

Name: nasti_slice

Overview:
- Parametrised multi-port NASTI register/buffer slice.
- Inserts an independent elastic FIFO on each of the five channels (AW, W, B, AR, R) of every port.
- Breaks long timing paths between crossbar, bridges and memory controllers.
- Supersedes plain wire-through combining; depth is selectable per channel, including a zero-depth bypass mode.

Parameters:
- N_PORT, 1, number of NASTI ports carried in the bundled interface
- ID_WIDTH, 1, id width
- ADDR_WIDTH, 8, address width
- DATA_WIDTH, 8, data width; multiple of 8
- USER_WIDTH, 1, user width; must be > 0
- AW_DEPTH, 2, AW FIFO entries per port; 0 = combinational bypass
- W_DEPTH, 2, W FIFO entries per port; 0 = bypass
- B_DEPTH, 2, B FIFO entries per port; 0 = bypass
- AR_DEPTH, 2, AR FIFO entries per port; 0 = bypass
- R_DEPTH, 2, R FIFO entries per port; 0 = bypass

Ports:
- clk  input  1  single clock for all logic
- rst  input  1  reset, asynchronous, active-high
- s  interface  nasti_channel.slave  upstream side, faces a master; same parameters as module
- m  interface  nasti_channel.master  downstream side, faces a slave; same parameters as module

Behaviour:
- Fixed: one clock clk; reset rst is asynchronous and active-high.
- Forward channels (AW, W, AR): the FIFO is pushed from s and popped to m.
- Reverse channels (B, R): the FIFO is pushed from m and popped to s.
- Payload per FIFO is the concatenation of all channel fields except valid/ready:
  - AW/AR: id, addr, len, size, burst, lock, cache, prot, qos, region, user.
  - W: data, strb, last, user.
  - B: id, resp, user.
  - R: id, data, resp, last, user.
- Each port/channel FIFO is independent; no ordering relation is enforced across channels or ports.
- DEPTH >= 1 mode:
  - in_ready = (count != DEPTH); registered, with no combinational path from out_ready.
  - push when in_valid & in_ready; pop when out_valid & out_ready.
  - out_valid = (count != 0).
  - Output payload is driven from the storage entry at the read pointer. It is not registered through logic after the pointer, and it holds stable while out_valid & !out_ready.
  - Latency: a beat accepted in cycle t is presented on the output in cycle t+1 at the earliest.
  - Throughput with DEPTH >= 2: one beat per cycle sustained.
  - Throughput with DEPTH = 1: one beat per two cycles, because a full FIFO deasserts in_ready.
  - Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
  - count width is $clog2(DEPTH+1).
  - Simultaneous push and pop while partially full: count unchanged, both pointers advance.
  - Push while full: blocked by in_ready = 0, even if a pop occurs in the same cycle.
  - Pop while empty: impossible, because out_valid = 0.
- DEPTH = 0 mode: out = in, out_valid = in_valid, in_ready = out_ready, all combinational. Holds no state and is unaffected by rst.
- Reset (rst high, asynchronous):
  - all counts and pointers clear to 0, so every out_valid goes to 0 immediately.
  - every in_ready reads 1.
  - storage contents are don't-care and need no reset.
- Reset mid-burst: in-flight beats are discarded. No partial-burst recovery; upstream is reset in the same domain.
- After rst deasserts, the first push may occur on the first rising edge.
- Valid/ready protocol: the slice never drops or duplicates a beat. It neither generates nor checks last, len or resp contents.

Decomposition:
- Package nasti_pkg:
  - localparam functions for per-channel payload widths: aw_w, w_w, b_w, ar_w, r_w, each computed from the interface parameters.
  - burst type and response codes for bench use.
- Sub-module nasti_slice_fifo, parameters WIDTH and DEPTH, signals clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
  - Contains the DEPTH = 0 bypass generate branch.
- Top level: a generate loop over N_PORT instantiates five nasti_slice_fifo per port and packs/unpacks the payloads.

Test Plan:
- Reset idle: rst high for 3 cycles with all inputs valid -> all m/s valids 0, all readies 1; after release, first AW beat (id=1, addr=0x40, len=3) appears on m.aw one cycle later with identical fields.
- Full throughput, W_DEPTH=2: 16 back-to-back W beats (data=0..15, last on 15), m.w_ready held 1 -> output in order, 1 beat per cycle, first beat at cycle 1, s.w_ready never drops.
- Backpressure, W_DEPTH=2: m.w_ready=0 while 3 beats are offered -> 2 accepted, s.w_ready=0 on the third. Payload is stable on m for all stall cycles. Release -> beats 0,1,2 delivered exactly once.
- Depth-1 and non-power-of-two, R_DEPTH=1 and 3: random valid/ready over 1000 beats -> scoreboard match. With depth 1, at most one beat every 2 cycles. With depth 3, pointer wrap is exercised and count never exceeds 3.
- Bypass, B_DEPTH=0: m.b_valid=1, b_id=2, resp=OKAY -> s.b_valid and fields in the same cycle; s.b_ready=0 -> m.b_ready=0 combinationally.
- Mid-operation reset, N_PORT=2: port 1 AR FIFO holds 2 entries and rst pulses asynchronously between edges -> m.ar_valid[1] falls immediately. No stale beat appears after release. Port 0 traffic resumes with correct data.

Source files
------------

// File: rtl/nasti_pkg.sv
// Shared NASTI field widths, payload-width helpers and encodings used by the slice.
package nasti_pkg;

  localparam int LEN_W    = 8;
  localparam int SIZE_W   = 3;
  localparam int BURST_W  = 2;
  localparam int LOCK_W   = 1;
  localparam int CACHE_W  = 4;
  localparam int PROT_W   = 3;
  localparam int QOS_W    = 4;
  localparam int REGION_W = 4;
  localparam int RESP_W   = 2;
  localparam int LAST_W   = 1;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  function automatic int aw_w(input int id_w, input int addr_w, input int user_w);
    return id_w + addr_w + LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W + PROT_W
           + QOS_W + REGION_W + user_w;
  endfunction

  function automatic int ar_w(input int id_w, input int addr_w, input int user_w);
    return aw_w(id_w, addr_w, user_w);
  endfunction

  function automatic int w_w(input int data_w, input int user_w);
    return data_w + data_w / 8 + LAST_W + user_w;
  endfunction

  function automatic int b_w(input int id_w, input int user_w);
    return id_w + RESP_W + user_w;
  endfunction

  function automatic int r_w(input int id_w, input int data_w, input int user_w);
    return id_w + data_w + RESP_W + LAST_W + user_w;
  endfunction

endpackage

// File: rtl/nasti_channel.sv
// Bundled NASTI interface carrying N_PORT independent ports; each field is packed per port.
interface nasti_channel #(
  parameter int N_PORT     = 1,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  import nasti_pkg::*;

  logic [N_PORT-1:0]                   aw_valid, aw_ready;
  logic [N_PORT-1:0][ID_WIDTH-1:0]     aw_id;
  logic [N_PORT-1:0][ADDR_WIDTH-1:0]   aw_addr;
  logic [N_PORT-1:0][LEN_W-1:0]        aw_len;
  logic [N_PORT-1:0][SIZE_W-1:0]       aw_size;
  logic [N_PORT-1:0][BURST_W-1:0]      aw_burst;
  logic [N_PORT-1:0][LOCK_W-1:0]       aw_lock;
  logic [N_PORT-1:0][CACHE_W-1:0]      aw_cache;
  logic [N_PORT-1:0][PROT_W-1:0]       aw_prot;
  logic [N_PORT-1:0][QOS_W-1:0]        aw_qos;
  logic [N_PORT-1:0][REGION_W-1:0]     aw_region;
  logic [N_PORT-1:0][USER_WIDTH-1:0]   aw_user;

  logic [N_PORT-1:0]                   w_valid, w_ready;
  logic [N_PORT-1:0][DATA_WIDTH-1:0]   w_data;
  logic [N_PORT-1:0][DATA_WIDTH/8-1:0] w_strb;
  logic [N_PORT-1:0]                   w_last;
  logic [N_PORT-1:0][USER_WIDTH-1:0]   w_user;

  logic [N_PORT-1:0]                   b_valid, b_ready;
  logic [N_PORT-1:0][ID_WIDTH-1:0]     b_id;
  logic [N_PORT-1:0][RESP_W-1:0]       b_resp;
  logic [N_PORT-1:0][USER_WIDTH-1:0]   b_user;

  logic [N_PORT-1:0]                   ar_valid, ar_ready;
  logic [N_PORT-1:0][ID_WIDTH-1:0]     ar_id;
  logic [N_PORT-1:0][ADDR_WIDTH-1:0]   ar_addr;
  logic [N_PORT-1:0][LEN_W-1:0]        ar_len;
  logic [N_PORT-1:0][SIZE_W-1:0]       ar_size;
  logic [N_PORT-1:0][BURST_W-1:0]      ar_burst;
  logic [N_PORT-1:0][LOCK_W-1:0]       ar_lock;
  logic [N_PORT-1:0][CACHE_W-1:0]      ar_cache;
  logic [N_PORT-1:0][PROT_W-1:0]       ar_prot;
  logic [N_PORT-1:0][QOS_W-1:0]        ar_qos;
  logic [N_PORT-1:0][REGION_W-1:0]     ar_region;
  logic [N_PORT-1:0][USER_WIDTH-1:0]   ar_user;

  logic [N_PORT-1:0]                   r_valid, r_ready;
  logic [N_PORT-1:0][ID_WIDTH-1:0]     r_id;
  logic [N_PORT-1:0][DATA_WIDTH-1:0]   r_data;
  logic [N_PORT-1:0][RESP_W-1:0]       r_resp;
  logic [N_PORT-1:0]                   r_last;
  logic [N_PORT-1:0][USER_WIDTH-1:0]   r_user;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );

endinterface

// File: rtl/nasti_slice_fifo.sv
// Elastic valid/ready FIFO for one channel: 1-cycle latency, in_ready depends only on occupancy.
// DEPTH = 0 collapses to plain wires with no state.
module nasti_slice_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid      = in_valid;
      assign in_ready       = out_ready;
      assign out_data       = in_data;
    end else begin : g_fifo
      localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int CW = $clog2(DEPTH + 1);
      localparam logic [CW-1:0] FULL = CW'(DEPTH);
      localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
      logic [CW-1:0]    count;
      logic             push, pop;

      // Ready comes straight from the count register, so no out_ready -> in_ready path.
      assign in_ready  = (count != FULL);
      assign out_valid = (count != '0);
      assign push      = in_valid & in_ready;
      assign pop       = out_valid & out_ready;
      assign out_data  = mem[rd_ptr];

      // Explicit wrap so non-power-of-two depths work.
      assign wr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      assign rd_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push) wr_ptr <= wr_nxt;
          if (pop)  rd_ptr <= rd_nxt;
          case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: rtl/nasti_slice.sv
// Multi-port NASTI register slice: an independent elastic FIFO on each of AW, W, B, AR, R per port.
// Forward channels flow s -> m, response channels m -> s; depth 0 on a channel means a wire bypass.
module nasti_slice
  import nasti_pkg::*;
#(
  parameter int N_PORT     = 1,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int AW_DEPTH   = 2,
  parameter int W_DEPTH    = 2,
  parameter int B_DEPTH    = 2,
  parameter int AR_DEPTH   = 2,
  parameter int R_DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  nasti_channel.slave  s,
  nasti_channel.master m
);

  localparam int AW_W = aw_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
  localparam int W_W  = w_w(DATA_WIDTH, USER_WIDTH);
  localparam int B_W  = b_w(ID_WIDTH, USER_WIDTH);
  localparam int AR_W = ar_w(ID_WIDTH, ADDR_WIDTH, USER_WIDTH);
  localparam int R_W  = r_w(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

  for (genvar p = 0; p < N_PORT; p++) begin : g_port
    logic [AW_W-1:0] aw_in, aw_out;
    logic [W_W-1:0]  w_in,  w_out;
    logic [B_W-1:0]  b_in,  b_out;
    logic [AR_W-1:0] ar_in, ar_out;
    logic [R_W-1:0]  r_in,  r_out;

    assign aw_in = {s.aw_id[p], s.aw_addr[p], s.aw_len[p], s.aw_size[p], s.aw_burst[p],
                    s.aw_lock[p], s.aw_cache[p], s.aw_prot[p], s.aw_qos[p],
                    s.aw_region[p], s.aw_user[p]};
    assign {m.aw_id[p], m.aw_addr[p], m.aw_len[p], m.aw_size[p], m.aw_burst[p],
            m.aw_lock[p], m.aw_cache[p], m.aw_prot[p], m.aw_qos[p],
            m.aw_region[p], m.aw_user[p]} = aw_out;

    assign w_in = {s.w_data[p], s.w_strb[p], s.w_last[p], s.w_user[p]};
    assign {m.w_data[p], m.w_strb[p], m.w_last[p], m.w_user[p]} = w_out;

    assign b_in = {m.b_id[p], m.b_resp[p], m.b_user[p]};
    assign {s.b_id[p], s.b_resp[p], s.b_user[p]} = b_out;

    assign ar_in = {s.ar_id[p], s.ar_addr[p], s.ar_len[p], s.ar_size[p], s.ar_burst[p],
                    s.ar_lock[p], s.ar_cache[p], s.ar_prot[p], s.ar_qos[p],
                    s.ar_region[p], s.ar_user[p]};
    assign {m.ar_id[p], m.ar_addr[p], m.ar_len[p], m.ar_size[p], m.ar_burst[p],
            m.ar_lock[p], m.ar_cache[p], m.ar_prot[p], m.ar_qos[p],
            m.ar_region[p], m.ar_user[p]} = ar_out;

    assign r_in = {m.r_id[p], m.r_data[p], m.r_resp[p], m.r_last[p], m.r_user[p]};
    assign {s.r_id[p], s.r_data[p], s.r_resp[p], s.r_last[p], s.r_user[p]} = r_out;

    nasti_slice_fifo #(.WIDTH(AW_W), .DEPTH(AW_DEPTH)) u_aw (
      .clk(clk), .rst(rst),
      .in_valid(s.aw_valid[p]), .in_ready(s.aw_ready[p]), .in_data(aw_in),
      .out_valid(m.aw_valid[p]), .out_ready(m.aw_ready[p]), .out_data(aw_out)
    );

    nasti_slice_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w (
      .clk(clk), .rst(rst),
      .in_valid(s.w_valid[p]), .in_ready(s.w_ready[p]), .in_data(w_in),
      .out_valid(m.w_valid[p]), .out_ready(m.w_ready[p]), .out_data(w_out)
    );

    // Response channels run upstream: pushed from m, popped towards s.
    nasti_slice_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(m.b_valid[p]), .in_ready(m.b_ready[p]), .in_data(b_in),
      .out_valid(s.b_valid[p]), .out_ready(s.b_ready[p]), .out_data(b_out)
    );

    nasti_slice_fifo #(.WIDTH(AR_W), .DEPTH(AR_DEPTH)) u_ar (
      .clk(clk), .rst(rst),
      .in_valid(s.ar_valid[p]), .in_ready(s.ar_ready[p]), .in_data(ar_in),
      .out_valid(m.ar_valid[p]), .out_ready(m.ar_ready[p]), .out_data(ar_out)
    );

    nasti_slice_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r (
      .clk(clk), .rst(rst),
      .in_valid(m.r_valid[p]), .in_ready(m.r_ready[p]), .in_data(r_in),
      .out_valid(s.r_valid[p]), .out_ready(s.r_ready[p]), .out_data(r_out)
    );
  end

endmodule

// File: tb/tb_nasti_slice.sv
// Bench for nasti_slice: directed scenarios plus random traffic against a per-channel queue model.
module tb_nasti_slice;
  import nasti_pkg::*;

  localparam int NCH = 11;  // 2 ports x 5 channels on u_dut, plus R of the depth-1 instance

  logic clk;
  logic rst;

  nasti_channel #(.N_PORT(2), .ID_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) sa ();
  nasti_channel #(.N_PORT(2), .ID_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) ma ();
  nasti_channel #(.N_PORT(1), .ID_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) sb ();
  nasti_channel #(.N_PORT(1), .ID_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1)) mb ();

  nasti_slice #(.N_PORT(2), .ID_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1),
                .AW_DEPTH(2), .W_DEPTH(2), .B_DEPTH(0), .AR_DEPTH(2), .R_DEPTH(3)) u_dut (
    .clk(clk), .rst(rst), .s(sa), .m(ma)
  );

  nasti_slice #(.N_PORT(1), .ID_WIDTH(2), .ADDR_WIDTH(8), .DATA_WIDTH(8), .USER_WIDTH(1),
                .AW_DEPTH(1), .W_DEPTH(1), .B_DEPTH(1), .AR_DEPTH(1), .R_DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .s(sb), .m(mb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  logic [63:0] q     [NCH][$];
  int          pops  [NCH];
  logic        stall [NCH];
  logic        clr_req;

  function automatic int depth_of(input int ch);
    if (ch == 10) return 1;
    case (ch % 5)
      2:       return 0;
      4:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic void check(input string nm, input int ch, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %h expected %h at %0t", nm, ch, act, exp, $time);
    end
  endfunction

  function automatic bit coin(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  task automatic sample(input int ch, output logic iv, output logic ir, output logic ov,
                        output logic ordy, output logic [63:0] id, output logic [63:0] od);
    int p;
    p = ch / 5;
    if (ch == 10) begin
      iv = mb.r_valid[0]; ir = mb.r_ready[0]; ov = sb.r_valid[0]; ordy = sb.r_ready[0];
      id = 64'({mb.r_id[0], mb.r_data[0], mb.r_resp[0], mb.r_last[0], mb.r_user[0]});
      od = 64'({sb.r_id[0], sb.r_data[0], sb.r_resp[0], sb.r_last[0], sb.r_user[0]});
    end else begin
      case (ch % 5)
        0: begin
          iv = sa.aw_valid[p]; ir = sa.aw_ready[p]; ov = ma.aw_valid[p]; ordy = ma.aw_ready[p];
          id = 64'({sa.aw_id[p], sa.aw_addr[p], sa.aw_len[p], sa.aw_size[p], sa.aw_burst[p],
                    sa.aw_lock[p], sa.aw_cache[p], sa.aw_prot[p], sa.aw_qos[p],
                    sa.aw_region[p], sa.aw_user[p]});
          od = 64'({ma.aw_id[p], ma.aw_addr[p], ma.aw_len[p], ma.aw_size[p], ma.aw_burst[p],
                    ma.aw_lock[p], ma.aw_cache[p], ma.aw_prot[p], ma.aw_qos[p],
                    ma.aw_region[p], ma.aw_user[p]});
        end
        1: begin
          iv = sa.w_valid[p]; ir = sa.w_ready[p]; ov = ma.w_valid[p]; ordy = ma.w_ready[p];
          id = 64'({sa.w_data[p], sa.w_strb[p], sa.w_last[p], sa.w_user[p]});
          od = 64'({ma.w_data[p], ma.w_strb[p], ma.w_last[p], ma.w_user[p]});
        end
        2: begin
          iv = ma.b_valid[p]; ir = ma.b_ready[p]; ov = sa.b_valid[p]; ordy = sa.b_ready[p];
          id = 64'({ma.b_id[p], ma.b_resp[p], ma.b_user[p]});
          od = 64'({sa.b_id[p], sa.b_resp[p], sa.b_user[p]});
        end
        3: begin
          iv = sa.ar_valid[p]; ir = sa.ar_ready[p]; ov = ma.ar_valid[p]; ordy = ma.ar_ready[p];
          id = 64'({sa.ar_id[p], sa.ar_addr[p], sa.ar_len[p], sa.ar_size[p], sa.ar_burst[p],
                    sa.ar_lock[p], sa.ar_cache[p], sa.ar_prot[p], sa.ar_qos[p],
                    sa.ar_region[p], sa.ar_user[p]});
          od = 64'({ma.ar_id[p], ma.ar_addr[p], ma.ar_len[p], ma.ar_size[p], ma.ar_burst[p],
                    ma.ar_lock[p], ma.ar_cache[p], ma.ar_prot[p], ma.ar_qos[p],
                    ma.ar_region[p], ma.ar_user[p]});
        end
        default: begin
          iv = ma.r_valid[p]; ir = ma.r_ready[p]; ov = sa.r_valid[p]; ordy = sa.r_ready[p];
          id = 64'({ma.r_id[p], ma.r_data[p], ma.r_resp[p], ma.r_last[p], ma.r_user[p]});
          od = 64'({sa.r_id[p], sa.r_data[p], sa.r_resp[p], sa.r_last[p], sa.r_user[p]});
        end
      endcase
    end
  endtask

  // Monitor/scoreboard: a FIFO of depth D is in-order storage of at most D beats.
  logic        m_iv, m_ir, m_ov, m_or;
  logic [63:0] m_id, m_od;
  int          m_d;
  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      m_d = depth_of(ch);
      sample(ch, m_iv, m_ir, m_ov, m_or, m_id, m_od);
      if (rst || clr_req) q[ch].delete();
      if (m_d == 0) begin
        check("byp_valid", ch, 64'(m_ov), 64'(m_iv));
        check("byp_ready", ch, 64'(m_ir), 64'(m_or));
        if (m_ov) check("byp_data", ch, m_od, m_id);
        if (m_ov && m_or) pops[ch]++;
      end else begin
        check("in_ready", ch, 64'(m_ir), 64'(q[ch].size() != m_d));
        check("out_valid", ch, 64'(m_ov), 64'(q[ch].size() != 0));
        if (m_ov && q[ch].size() != 0) check("out_data", ch, m_od, q[ch][0]);
        if (!rst) begin
          if (m_ov && m_or && q[ch].size() != 0) begin
            void'(q[ch].pop_front());
            pops[ch]++;
          end
          if (m_iv && m_ir) q[ch].push_back(m_id);
        end
      end
      stall[ch] = m_iv && !m_ir;
    end
    clr_req = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      sa.aw_valid[p] = 1'b0; sa.w_valid[p] = 1'b0; sa.ar_valid[p] = 1'b0;
      ma.b_valid[p]  = 1'b0; ma.r_valid[p] = 1'b0;
      ma.aw_ready[p] = 1'b1; ma.w_ready[p] = 1'b1; ma.ar_ready[p] = 1'b1;
      sa.b_ready[p]  = 1'b1; sa.r_ready[p] = 1'b1;
    end
    sb.aw_valid[0] = 1'b0; sb.w_valid[0] = 1'b0; sb.ar_valid[0] = 1'b0;
    mb.b_valid[0]  = 1'b0; mb.r_valid[0] = 1'b0;
    mb.aw_ready[0] = 1'b1; mb.w_ready[0] = 1'b1; mb.ar_ready[0] = 1'b1;
    sb.b_ready[0]  = 1'b1; sb.r_ready[0] = 1'b1;
  endtask

  // A beat offered but not yet accepted is held unchanged (stall[]), as the protocol demands.
  task automatic rand_step(input int pv, input int pr);
    logic [63:0] r;
    for (int p = 0; p < 2; p++) begin
      r = {$urandom, $urandom};
      if (!stall[p*5+0]) begin
        sa.aw_valid[p] = coin(pv); sa.aw_id[p] = r[1:0]; sa.aw_addr[p] = r[9:2];
        sa.aw_len[p] = r[17:10]; sa.aw_size[p] = r[20:18]; sa.aw_burst[p] = r[22:21];
        sa.aw_lock[p] = r[23:23]; sa.aw_cache[p] = r[27:24]; sa.aw_prot[p] = r[30:28];
        sa.aw_qos[p] = r[34:31]; sa.aw_region[p] = r[38:35]; sa.aw_user[p] = r[39:39];
      end
      r = {$urandom, $urandom};
      if (!stall[p*5+1]) begin
        sa.w_valid[p] = coin(pv); sa.w_data[p] = r[7:0]; sa.w_strb[p] = r[8:8];
        sa.w_last[p] = r[9]; sa.w_user[p] = r[10:10];
      end
      r = {$urandom, $urandom};
      if (!stall[p*5+2]) begin
        ma.b_valid[p] = coin(pv); ma.b_id[p] = r[1:0]; ma.b_resp[p] = r[3:2];
        ma.b_user[p] = r[4:4];
      end
      r = {$urandom, $urandom};
      if (!stall[p*5+3]) begin
        sa.ar_valid[p] = coin(pv); sa.ar_id[p] = r[1:0]; sa.ar_addr[p] = r[9:2];
        sa.ar_len[p] = r[17:10]; sa.ar_size[p] = r[20:18]; sa.ar_burst[p] = r[22:21];
        sa.ar_lock[p] = r[23:23]; sa.ar_cache[p] = r[27:24]; sa.ar_prot[p] = r[30:28];
        sa.ar_qos[p] = r[34:31]; sa.ar_region[p] = r[38:35]; sa.ar_user[p] = r[39:39];
      end
      r = {$urandom, $urandom};
      if (!stall[p*5+4]) begin
        ma.r_valid[p] = coin(pv); ma.r_id[p] = r[1:0]; ma.r_data[p] = r[9:2];
        ma.r_resp[p] = r[11:10]; ma.r_last[p] = r[12]; ma.r_user[p] = r[13:13];
      end
      ma.aw_ready[p] = coin(pr); ma.w_ready[p] = coin(pr); ma.ar_ready[p] = coin(pr);
      sa.b_ready[p]  = coin(pr); sa.r_ready[p] = coin(pr);
    end
    r = {$urandom, $urandom};
    if (!stall[10]) begin
      mb.r_valid[0] = coin(pv); mb.r_id[0] = r[1:0]; mb.r_data[0] = r[9:2];
      mb.r_resp[0] = r[11:10]; mb.r_last[0] = r[12]; mb.r_user[0] = r[13:13];
    end
    sb.r_ready[0] = coin(pr);
  endtask

  int p0;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_req  = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      pops[ch]  = 0;
      stall[ch] = 1'b0;
    end
    rst = 1'b1;
    idle();
    for (int p = 0; p < 2; p++) begin
      sa.aw_valid[p] = 1'b1; sa.w_valid[p] = 1'b1; sa.ar_valid[p] = 1'b1;
      ma.b_valid[p]  = 1'b1; ma.r_valid[p] = 1'b1;
    end
    mb.r_valid[0] = 1'b1;

    // Reset idle with every input valid; the monitor expects empty FIFOs and ready inputs.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // First AW beat after reset release.
    sa.aw_valid[0] = 1'b1; sa.aw_id[0] = 2'd1; sa.aw_addr[0] = 8'h40; sa.aw_len[0] = 8'd3;
    sa.aw_size[0] = 3'd0; sa.aw_burst[0] = BURST_INCR; sa.aw_lock[0] = 1'b0;
    sa.aw_cache[0] = 4'd0; sa.aw_prot[0] = 3'd0; sa.aw_qos[0] = 4'd0;
    sa.aw_region[0] = 4'd0; sa.aw_user[0] = 1'b0;
    step();
    sa.aw_valid[0] = 1'b0;
    @(negedge clk);
    check("aw_first_valid", 0, 64'(ma.aw_valid[0]), 64'd1);
    check("aw_first_id",    0, 64'(ma.aw_id[0]),    64'd1);
    check("aw_first_addr",  0, 64'(ma.aw_addr[0]),  64'h40);
    check("aw_first_len",   0, 64'(ma.aw_len[0]),   64'd3);
    step();

    // Full-throughput W burst of 16 beats.
    p0 = pops[1];
    for (int i = 0; i < 16; i++) begin
      sa.w_valid[0] = 1'b1; sa.w_data[0] = 8'(i); sa.w_strb[0] = 1'b1;
      sa.w_last[0] = (i == 15); sa.w_user[0] = 1'b0;
      step();
    end
    sa.w_valid[0] = 1'b0;
    step();
    check("w_tput_beats", 1, 64'(pops[1] - p0), 64'd16);

    // Backpressure: two beats fit, the third is refused until the sink drains.
    ma.w_ready[0] = 1'b0;
    p0 = pops[1];
    for (int i = 0; i < 2; i++) begin
      sa.w_valid[0] = 1'b1; sa.w_data[0] = 8'(i); sa.w_last[0] = 1'b0;
      step();
    end
    sa.w_data[0] = 8'd2; sa.w_last[0] = 1'b1;
    @(negedge clk);
    check("w_full_ready", 1, 64'(sa.w_ready[0]), 64'd0);
    check("w_stall_data", 1, 64'(ma.w_data[0]), 64'd0);
    repeat (3) step();
    ma.w_ready[0] = 1'b1;
    step();
    step();
    sa.w_valid[0] = 1'b0;
    step();
    step();
    check("w_bp_beats", 1, 64'(pops[1] - p0), 64'd3);

    // Bypass B channel: combinational in both directions.
    ma.b_valid[0] = 1'b1; ma.b_id[0] = 2'd2; ma.b_resp[0] = RESP_OKAY; ma.b_user[0] = 1'b0;
    sa.b_ready[0] = 1'b0;
    #1;
    check("b_byp_valid", 2, 64'(sa.b_valid[0]), 64'd1);
    check("b_byp_id",    2, 64'(sa.b_id[0]),    64'd2);
    check("b_byp_resp",  2, 64'(sa.b_resp[0]),  64'(RESP_OKAY));
    check("b_byp_ready", 2, 64'(ma.b_ready[0]), 64'd0);
    sa.b_ready[0] = 1'b1;
    #1;
    check("b_byp_ready1", 2, 64'(ma.b_ready[0]), 64'd1);
    step();
    ma.b_valid[0] = 1'b0;
    step();

    // Port 1 AR holds two beats, then an asynchronous reset pulse between edges.
    ma.ar_ready[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sa.ar_valid[1] = 1'b1; sa.ar_id[1] = 2'(i); sa.ar_addr[1] = 8'(8'h80 + i);
      step();
    end
    sa.ar_valid[1] = 1'b0;
    check("ar1_held_valid", 8, 64'(ma.ar_valid[1]), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("ar1_rst_valid", 8, 64'(ma.ar_valid[1]), 64'd0);
    check("ar1_rst_ready", 8, 64'(sa.ar_ready[1]), 64'd1);
    #1 rst = 1'b0;
    clr_req = 1'b1;
    step();
    ma.ar_ready[1] = 1'b1;
    step();
    step();
    check("ar1_no_stale", 8, 64'(ma.ar_valid[1]), 64'd0);

    // Random traffic on every channel, including the depth-1 and depth-3 R FIFOs.
    repeat (6000) begin
      rand_step(75, 70);
      step();
    end
    repeat (20) begin
      rand_step(0, 100);
      step();
    end
    check("r_d3_beats_ge1000", 4,  64'(pops[4] >= 1000),  64'd1);
    check("r_d1_beats_ge1000", 10, 64'(pops[10] >= 1000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
